// File: rtl/bram_fifo_ctrl.sv
// FIFO controller for an external dual-port block RAM (1-cycle read) with a 2-entry output buffer.
// Optional feature: define BRAM_FIFO_PARITY_CHK_EN to generate write parity and check read parity.
`timescale 1ns/1ps
module bram_fifo_ctrl #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [15:0]       in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [15:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W+1:0] level,
   output logic [9:0]        addra,
   output logic [15:0]       dia,
   output logic [1:0]        dipa,
   output logic              ena,
   output logic              wea,
   output logic [9:0]        addrb,
   output logic              enb,
   input  logic [15:0]       dob,
   input  logic [1:0]        dopb,
   output logic              par_err,
   output logic              par_err_stky
);

   localparam int              DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   ram_cnt;
   logic [ADDR_W:0]   ram_cnt_nxt;
   logic              rd_pend;
   logic              rd_pend_nxt;
   logic [1:0]        ob_cnt;
   logic [1:0]        ob_cnt_nxt;
   logic              ob_head;
   logic [15:0]       ob_mem [2];
   logic [2:0]        ob_occ;
   logic              push;
   logic              pop;
   logic              issue;
   logic              capture;

   // Handshakes. Writes are held off while reset is asserted so the RAM port stays idle.
   assign in_ready  = (ram_cnt != FULL);
   assign push      = in_valid & in_ready & ~flush & rst_n;
   assign out_valid = (ob_cnt != 2'd0);
   assign out_data  = ob_mem[ob_head];
   assign pop       = out_valid & out_ready & ~flush;

   // A read is only launched when its data is sure to find a free output-buffer slot.
   assign ob_occ  = {1'b0, ob_cnt} + {2'b00, rd_pend};
   assign issue   = (ram_cnt != '0) & ~flush & (ob_occ < (3'd2 + 3'(pop)));
   assign capture = rd_pend & ~flush;

   assign ena   = push;
   assign wea   = push;
   assign addra = 10'(wr_ptr);
   assign dia   = in_data;
   assign enb   = issue;
   assign addrb = 10'(rd_ptr);

   // NOTE: combinational logic uses blocking assignments and gives every output a default
   // first, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      ram_cnt_nxt = ram_cnt;
      rd_pend_nxt = issue;
      ob_cnt_nxt  = ob_cnt;
      if (flush) begin
         ram_cnt_nxt = '0;
         rd_pend_nxt = 1'b0;
         ob_cnt_nxt  = 2'd0;
      end else begin
         ram_cnt_nxt = ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
         ob_cnt_nxt  = ob_cnt + 2'(capture) - 2'(pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ram_cnt <= '0;
         rd_pend <= 1'b0;
         ob_cnt  <= 2'd0;
         ob_head <= 1'b0;
         level   <= '0;
      end else begin
         ram_cnt <= ram_cnt_nxt;
         rd_pend <= rd_pend_nxt;
         ob_cnt  <= ob_cnt_nxt;
         level   <= (ADDR_W+2)'(ram_cnt_nxt) + (ADDR_W+2)'(rd_pend_nxt)
                  + (ADDR_W+2)'(ob_cnt_nxt);
         if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ob_head <= 1'b0;
         end else begin
            if (push)  wr_ptr  <= wr_ptr + ADDR_W'(1);
            if (issue) rd_ptr  <= rd_ptr + ADDR_W'(1);
            if (pop)   ob_head <= ~ob_head;
         end
      end
   end

   // NOTE: the two output-buffer words are reset so out_data reads 0 out of reset;
   // the block RAM behind the FIFO is never cleared and its contents are never trusted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ob_mem[0] <= '0;
         ob_mem[1] <= '0;
      end else if (capture) begin
         ob_mem[ob_head ^ ob_cnt[0]] <= dob;
      end
   end

`ifdef BRAM_FIFO_PARITY_CHK_EN
   logic par_mis;

   // Odd parity per byte: the parity bit makes the 9-bit group hold an odd number of ones.
   assign dipa    = {~^in_data[15:8], ~^in_data[7:0]};
   assign par_mis = (dopb != {~^dob[15:8], ~^dob[7:0]});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err      <= 1'b0;
         par_err_stky <= 1'b0;
      end else begin
         par_err <= capture & par_mis;
         if (flush)                  par_err_stky <= 1'b0;
         else if (capture & par_mis) par_err_stky <= 1'b1;
      end
   end
`else
   logic unused_dopb;

   assign dipa         = 2'b00;
   assign par_err      = 1'b0;
   assign par_err_stky = 1'b0;
   assign unused_dopb  = ^dopb;
`endif

   // Structural invariants of the pointer/count scheme.
   a_no_collision : assert property (@(posedge clk) disable iff (!rst_n)
      !(ena && enb && (addra == addrb)));
   a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
      ram_cnt <= FULL);
   a_ob_room : assert property (@(posedge clk) disable iff (!rst_n)
      !(capture && (ob_cnt == 2'd2)));

endmodule
